mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_array.sv | 22 ++
 rtl/mem_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory controller slice: word geometry, default latency
// and the FSM state encoding.
package mem_pkg;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int LAT_DEFAULT   = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/mem_array.sv
// Single-port main-memory storage: synchronous write, asynchronous read, no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     CLK,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WORD_W-1:0]        i_wdata,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_ctrl.sv
// Fixed-latency word-transfer controller between cache and main memory.
// Optional MEM_BURST_EN: same-block follow-on words (offset != 0) complete in one cycle.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int LAT   = LAT_DEFAULT,
  parameter int DEPTH = 1024
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MReq,
  input  logic              MWE,
  input  logic [31:0]       Addr,
  input  logic [1:0]        BlockOffset,
  input  logic [WORD_W-1:0] WData,
  output logic              MReady,
  output logic [WORD_W-1:0] RData
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [AW-1:0]     r_idx;
  logic              r_we;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;

  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     w_mem_addr;
  logic [WORD_W-1:0] w_mem_rd;
  logic              w_mem_we;
  logic              w_hit;
  logic              w_unused;

  // Word index wraps modulo DEPTH; the byte-within-block bits are don't-care.
  assign w_idx    = AW'({Addr[31:4], BlockOffset});
  assign w_unused = ^Addr[3:0];

  // Port is shared: IDLE looks up the incoming request, later states use the capture.
  assign w_mem_addr = (r_state == ST_IDLE) ? w_idx : r_idx;
  assign w_mem_we   = (r_state == ST_DONE) && r_we && !Reset;

  mem_array #(.DEPTH(DEPTH)) u_array (
    .CLK     (CLK),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rd)
  );

`ifdef MEM_BURST_EN
  logic        r_tag_vld;
  logic [27:0] r_tag;
  logic [27:0] r_blk;

  assign w_hit = r_tag_vld && (r_tag == Addr[31:4]) && (BlockOffset != 2'd0);

  always_ff @(posedge CLK) begin
    if (Reset)                                  r_tag_vld <= 1'b0;
    else if ((r_state == ST_WAIT) && !MReq)     r_tag_vld <= 1'b0;
    else if (r_state == ST_DONE)                r_tag_vld <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if ((r_state == ST_IDLE) && MReq) r_blk <= Addr[31:4];
    if (r_state == ST_DONE)           r_tag <= r_blk;
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if ((r_state == ST_IDLE) && MReq) begin
      r_idx   <= w_idx;
      r_we    <= MWE;
      r_wdata <= WData;
    end
  end

  // Read data is latched on entry to DONE so it is stable for the whole pulse and holds afterwards.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (MReq) begin
            if ((LAT == 1) || w_hit) begin
              r_state <= ST_DONE;
              if (!MWE) r_rdata <= w_mem_rd;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!MReq) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            if (!r_we) r_rdata <= w_mem_rd;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MReady = (r_state == ST_DONE);
  assign RData  = r_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized + directed bench for mem_ctrl (LAT=4 and LAT=1 instances) against a
// transaction-level memory model; follows MEM_BURST_EN if defined at compile time.
module tb_mem_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        mreq  [2];
  logic        mwe   [2];
  logic [31:0] addr  [2];
  logic [1:0]  boff  [2];
  logic [31:0] wdata [2];
  logic        mready[2];
  logic [31:0] rdata [2];

  always #5 CLK = ~CLK;

  mem_ctrl #(.LAT(4), .DEPTH(1024)) dut (
    .CLK(CLK), .Reset(Reset), .MReq(mreq[0]), .MWE(mwe[0]), .Addr(addr[0]),
    .BlockOffset(boff[0]), .WData(wdata[0]), .MReady(mready[0]), .RData(rdata[0])
  );

  mem_ctrl #(.LAT(1), .DEPTH(1024)) dut1 (
    .CLK(CLK), .Reset(Reset), .MReq(mreq[1]), .MWE(mwe[1]), .Addr(addr[1]),
    .BlockOffset(boff[1]), .WData(wdata[1]), .MReady(mready[1]), .RData(rdata[1])
  );

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] mem_m [int];
  bit          tag_v [2];
  logic [27:0] tag   [2];
  logic [31:0] last_rd [2];
  bit          hold_known [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a, input logic [1:0] off);
    return int'((((a >> 4) * 32'd4) + 32'(off)) % 32'd1024);
  endfunction

  task automatic xfer(input int s, input bit we, input logic [31:0] a,
                      input logic [1:0] off, input logic [31:0] wd);
    int lat, n, key;
    bit known;
    lat = (s == 0) ? 4 : 1;
`ifdef MEM_BURST_EN
    if (tag_v[s] && tag[s] == a[31:4] && off != 2'd0) lat = 1;
`endif
    key   = s * 4096 + widx(a, off);
    known = mem_m.exists(key);
    @(negedge CLK);
    mreq[s] = 1'b1; mwe[s] = we; addr[s] = a; boff[s] = off; wdata[s] = wd;
    @(posedge CLK); #1;
    n = 1;
    while (!mready[s] && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    if (!we && known) chk("rdata", rdata[s], mem_m[key]);
    mreq[s] = 1'b0;
    @(posedge CLK); #1;
    chk("pulse_width", {31'd0, mready[s]}, 32'd0);
    if (we) mem_m[key] = wd;
    else if (known) begin
      last_rd[s] = mem_m[key];
      hold_known[s] = 1'b1;
    end else hold_known[s] = 1'b0;
    if (hold_known[s]) chk("rdata_hold", rdata[s], last_rd[s]);
    tag_v[s] = 1'b1;
    tag[s]   = a[31:4];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] blks [4];
    blks[0] = 32'h200; blks[1] = 32'h300; blks[2] = 32'h400; blks[3] = 32'h500;
    for (int s = 0; s < 2; s++) begin
      mreq[s] = 0; mwe[s] = 0; addr[s] = 0; boff[s] = 0; wdata[s] = 0;
      tag_v[s] = 0; tag[s] = 0; last_rd[s] = 0; hold_known[s] = 1;
    end
    Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_mready0", {31'd0, mready[0]}, 32'd0);
    chk("rst_rdata0", rdata[0], 32'd0);
    chk("rst_mready1", {31'd0, mready[1]}, 32'd0);
    chk("rst_rdata1", rdata[1], 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // Single fill at LAT=4, and LAT=1 on the second instance.
    xfer(0, 1, 32'h100, 2'd0, 32'hDEADBEEF);
    xfer(0, 0, 32'h100, 2'd0, 32'h0);
    xfer(1, 1, 32'h100, 2'd0, 32'hCAFEF00D);
    xfer(1, 0, 32'h100, 2'd0, 32'h0);

    for (int s = 0; s < 2; s++)
      for (int b = 0; b < 4; b++)
        for (int o = 0; o < 4; o++)
          xfer(s, 1, blks[b], 2'(o), $urandom);

    // Four-word block fill, then write-then-read coherence.
    for (int o = 0; o < 4; o++) xfer(0, 0, 32'h200, 2'(o), 32'h0);
    xfer(0, 1, 32'h300, 2'd2, 32'h12345678);
    xfer(0, 0, 32'h300, 2'd2, 32'h0);

    // Abort a write two cycles in: no pulse, array unchanged.
    @(negedge CLK);
    mreq[0] = 1; mwe[0] = 1; addr[0] = 32'h100; boff[0] = 2'd0; wdata[0] = 32'h0BADF00D;
    @(posedge CLK); #1;
    chk("abort_c1", {31'd0, mready[0]}, 32'd0);
    @(posedge CLK); #1;
    chk("abort_c2", {31'd0, mready[0]}, 32'd0);
    mreq[0] = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("abort_no_ready", {31'd0, mready[0]}, 32'd0);
    end
    tag_v[0] = 0;
    xfer(0, 0, 32'h100, 2'd0, 32'h0);

    // Reset during WAIT.
    @(negedge CLK);
    mreq[0] = 1; mwe[0] = 0; addr[0] = 32'h200; boff[0] = 2'd1;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk("rstwait_mready", {31'd0, mready[0]}, 32'd0);
    chk("rstwait_rdata", rdata[0], 32'd0);
    chk("rstwait_rdata1", rdata[1], 32'd0);
    mreq[0] = 0;
    @(negedge CLK);
    Reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tag_v[s] = 0; last_rd[s] = 0; hold_known[s] = 1;
    end
    xfer(0, 0, 32'h300, 2'd2, 32'h0);
    xfer(0, 0, 32'h100, 2'd0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      int s;
      bit we;
      s  = int'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) == 0);
      xfer(s, we, blks[$urandom_range(0, 3)] | 32'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
